// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches awaiting resolution from execute. Detects mispredicts,
// generates a registered flush/redirect, trains the direction predictor and keeps statistics.
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            enq_valid_i,
    output logic            enq_ready_o,
    input  logic [PC_W-1:0] enq_pc_i,
    input  logic            enq_taken_i,
    input  logic [PC_W-1:0] enq_target_i,

    input  logic            res_valid_i,
    input  logic            res_taken_i,
    input  logic [PC_W-1:0] res_target_i,
    input  logic [1:0]      res_jumptype_i,

    output logic            upd_valid_o,
    output logic [PC_W-1:0] upd_pc_o,
    output logic            upd_taken_o,
    output logic [1:0]      upd_jumptype_o,

    output logic            flush_o,
    output logic [PC_W-1:0] redirect_pc_o,

    output logic [AW:0]     count_o,
    output logic [31:0]     br_cnt_o,
    output logic [31:0]     mis_cnt_o,
    output logic            err_o
);

    // Entry storage is never reset; pointers alone define validity.
    logic [PC_W-1:0] pc_mem     [DEPTH];
    logic            taken_mem  [DEPTH];
    logic [PC_W-1:0] target_mem [DEPTH];

    logic [AW:0]     head_q, head_d;
    logic [AW:0]     tail_q, tail_d;
    logic            run_q;
    logic            flush_q;
    logic [PC_W-1:0] redirect_q, redirect_d;
    logic            upd_valid_q;
    logic [PC_W-1:0] upd_pc_q;
    logic            upd_taken_q;
    logic [1:0]      upd_jt_q;
    logic [31:0]     br_cnt_q, br_cnt_d;
    logic [31:0]     mis_cnt_q, mis_cnt_d;
    logic            err_q, err_d;

    logic            full, empty;
    logic            res_acc, enq_acc, is_branch, mispredict, flush_now;
    logic [PC_W-1:0] head_pc, head_target;
    logic            head_taken;

    assign full  = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
    assign empty = (head_q == tail_q);

    assign head_pc     = pc_mem[head_q[AW-1:0]];
    assign head_taken  = taken_mem[head_q[AW-1:0]];
    assign head_target = target_mem[head_q[AW-1:0]];

    // run_q keeps every input ignored until the first edge after reset release.
    assign res_acc    = run_q && res_valid_i && !empty;
    assign is_branch  = (res_jumptype_i != 2'd0);
    assign mispredict = (head_taken != res_taken_i) ||
                        (head_taken && res_taken_i && (head_target != res_target_i));
    assign flush_now  = res_acc && mispredict;

    assign enq_ready_o = run_q && !full && !flush_now;
    assign enq_acc     = enq_valid_i && enq_ready_o;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        redirect_d = redirect_q;
        br_cnt_d   = br_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        err_d      = err_q;

        if (flush_now) begin
            // Drop everything outstanding; the concurrent enqueue was already refused.
            head_d     = tail_q;
            redirect_d = res_taken_i ? res_target_i : head_pc + PC_W'(4);
        end else begin
            if (res_acc) begin
                head_d = head_q + 1'b1;
            end
            if (enq_acc) begin
                tail_d = tail_q + 1'b1;
            end
        end

        if (res_acc && is_branch && (br_cnt_q != 32'hFFFF_FFFF)) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (flush_now && (mis_cnt_q != 32'hFFFF_FFFF)) begin
            mis_cnt_d = mis_cnt_q + 32'd1;
        end
        if (run_q && res_valid_i && empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q      <= '0;
            tail_q      <= '0;
            run_q       <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
            upd_jt_q    <= '0;
            br_cnt_q    <= '0;
            mis_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            run_q       <= 1'b1;
            flush_q     <= flush_now;
            redirect_q  <= redirect_d;
            upd_valid_q <= res_acc && is_branch;
            if (res_acc && is_branch) begin
                upd_pc_q    <= head_pc;
                upd_taken_q <= res_taken_i;
                upd_jt_q    <= res_jumptype_i;
            end
            br_cnt_q    <= br_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_acc) begin
            pc_mem[tail_q[AW-1:0]]     <= enq_pc_i;
            taken_mem[tail_q[AW-1:0]]  <= enq_taken_i;
            target_mem[tail_q[AW-1:0]] <= enq_target_i;
        end
    end

    assign upd_valid_o    = upd_valid_q;
    assign upd_pc_o       = upd_pc_q;
    assign upd_taken_o    = upd_taken_q;
    assign upd_jumptype_o = upd_jt_q;
    assign flush_o        = flush_q;
    assign redirect_pc_o  = redirect_q;
    assign count_o        = tail_q - head_q;
    assign br_cnt_o       = br_cnt_q;
    assign mis_cnt_o      = mis_cnt_q;
    assign err_o          = err_q;

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, number of in-flight predictions (power of two); PC_W, 64, PC/target width.
REQ-002 clock  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 enq_valid  input  1  fetch has issued a predicted branch/jump.
REQ-005 enq_ready  output  1  queue can accept an entry this cycle.
REQ-006 enq_pc  input  PC_W  PC of the predicted instruction.
REQ-007 enq_taken  input  1  predicted direction.
REQ-008 enq_target  input  PC_W  predicted target; ignored when enq_taken=0.
REQ-009 res_valid  input  1  execute resolves the oldest outstanding entry.
REQ-010 res_taken  input  1  actual direction.
REQ-011 res_target  input  PC_W  actual taken target.
REQ-012 res_jumptype  input  2  branch class; 0 = not a control-flow instruction.
REQ-013 upd_valid, upd_pc[PC_W], upd_taken, upd_jumptype[2]  outputs  training port to the direction predictor.
REQ-014 flush  output  1  mispredict; front-end SHALL discard younger work.
REQ-015 redirect_pc  output  PC_W  correct fetch address, valid when flush=1.
REQ-016 count  output  log2(DEPTH)+1  outstanding entries.
REQ-017 br_cnt, mis_cnt  outputs  32  resolved-branch and mispredict counters.
REQ-018 err  output  1  sticky protocol error.

Function
REQ-019 The queue SHALL be a circular FIFO of DEPTH entries {pc, taken, target} with head/tail pointers one bit wider than the index; full = pointers equal except MSB, empty = pointers fully equal.
REQ-020 enq_ready SHALL be 1 iff not full and flush is not being generated this cycle; an entry SHALL be written when enq_valid&&enq_ready.
REQ-021 No bypass: enqueue while full SHALL be refused even if a resolution occurs in the same cycle.
REQ-022 A resolution SHALL be accepted iff res_valid && !empty; it SHALL pop the head entry.
REQ-023 res_valid while empty SHALL set err (sticky until reset) and change nothing else.
REQ-024 Mispredict SHALL be: entry.taken != res_taken, or both taken and entry.target != res_target.
REQ-025 redirect_pc SHALL be res_target if res_taken, else entry.pc + 4 (modulo 2^PC_W).
REQ-026 flush and redirect_pc SHALL be registered: asserted for exactly one cycle, the cycle after the accepted mispredicting resolution.
REQ-027 On a mispredicting resolution the whole queue SHALL be emptied at that same edge; a simultaneous enqueue SHALL be dropped (enq_ready=0 that cycle).
REQ-028 Resolution of a correct prediction with a simultaneous enqueue SHALL leave count unchanged.
REQ-029 upd_* SHALL be registered one cycle after each accepted resolution with res_jumptype != 0, carrying entry.pc, res_taken, res_jumptype; upd_valid SHALL be 0 otherwise.
REQ-030 br_cnt SHALL increment on each accepted resolution with jumptype != 0; mis_cnt on each mispredict; both SHALL saturate at 0xFFFF_FFFF.
REQ-031 count SHALL equal tail - head and be valid combinationally from the pointers.

Reset
REQ-032 While reset=0, pointers, count, flush, upd_valid, err, br_cnt, mis_cnt SHALL be 0, redirect_pc and upd_* data 0, enq_ready 0; entry storage need not be cleared.
REQ-033 Reset asserted mid-operation SHALL immediately clear all state above; inputs SHALL be ignored until the first rising edge after reset=1; enq_ready SHALL be 1 from then.

Verification
REQ-034 Fill: 4 enqueues, pc 0x8000_0000..0x8000_000C, no resolves -> count=4, enq_ready=0; 5th enq_valid refused.
REQ-035 Correct predict: head pc 0x8000_0000 taken target 0x8000_0100; resolve taken, 0x8000_0100, jumptype=1 -> next cycle upd_valid=1, upd_pc=0x8000_0000, upd_taken=1, flush=0, br_cnt=1.
REQ-036 Direction mispredict: head pc 0x8000_0010 predicted taken; resolve not-taken, jumptype=1 -> next cycle flush=1 for one cycle, redirect_pc=0x8000_0014, count=0, mis_cnt=1.
REQ-037 Full + resolve + enqueue same cycle with correct prediction -> enqueue refused, count 4->3; enqueue with count=2 and correct resolve -> count stays 2.
REQ-038 res_valid with empty queue -> err=1 and stays 1; count stays 0, upd_valid=0.
REQ-039 Reset pulse (reset=0 for one cycle) with count=3 mid-stream -> count=0, flush=0, counters 0 immediately, before the next clock edge.
